riscorvo_mem_arbiter: RTL



---
 rtl/riscorvo_pkg.sv | 25 ++
 rtl/riscorvo_mem_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/riscorvo_pkg.sv
// Shared types and constants for the riscorvo memory subsystem.
//   arb_state_t   : memory arbiter FSM states
//   mem_req_t     : latched memory request payload (addr, wdata, rw, mask)
//   MEM_MASK_WORD : byte-enable pattern for a full-word access
package riscorvo_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned MASK_W = 4;

  localparam logic [MASK_W-1:0] MEM_MASK_WORD = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic              rw;
    logic [MASK_W-1:0] mask;
  } mem_req_t;

endpackage

// File: rtl/riscorvo_mem_arbiter.sv
// Shares one memory port between the core's fetch and data interfaces.
// Data has priority; a streak counter lets a pending fetch win after
// MAX_DATA_STREAK consecutive data grants made from IDLE. A watchdog aborts a
// granted access that sees no ready_i within TIMEOUT_CYCLES (0 disables it).
// Ports:
//   clk, reset_n                         clock, synchronous active-low reset
//   valid_instr_i/addr_instr_i           fetch request
//   ready_instr_o/data_instr_o           fetch completion pulse and read data
//   valid_data_i/addr_data_i/write_data_i/read_write_i/mask_data_i
//                                        data request
//   ready_data_o/read_data_o             data completion pulse and load data
//   valid_o/addr_o/write_data_o/read_write_o/mask_o
//                                        latched memory request
//   ready_i/read_data_i                  memory completion and read data
//   err_o                                pulse on watchdog abort
module riscorvo_mem_arbiter
  import riscorvo_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_instr_i,
  input  logic [XLEN-1:0]   addr_instr_i,
  output logic              ready_instr_o,
  output logic [XLEN-1:0]   data_instr_o,
  input  logic              valid_data_i,
  input  logic [XLEN-1:0]   addr_data_i,
  input  logic [XLEN-1:0]   write_data_i,
  input  logic              read_write_i,
  input  logic [MASK_W-1:0] mask_data_i,
  output logic              ready_data_o,
  output logic [XLEN-1:0]   read_data_o,
  output logic              valid_o,
  output logic [XLEN-1:0]   addr_o,
  output logic [XLEN-1:0]   write_data_o,
  output logic              read_write_o,
  output logic [MASK_W-1:0] mask_o,
  input  logic              ready_i,
  input  logic [XLEN-1:0]   read_data_i,
  output logic              err_o
);

  localparam int unsigned STREAK_W = 4;
  localparam int unsigned WDOG_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_DATA_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_MAX   = '1;
  // Abort fires in the TIMEOUT_CYCLES-th granted cycle, i.e. count == limit-1.
  localparam logic [WDOG_W-1:0]   WDOG_LAST    =
    WDOG_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [WDOG_W-1:0]   WDOG_MAX     = '1;

  arb_state_t          r_state, w_state_nxt;
  mem_req_t            r_req, w_req_nxt;
  mem_req_t            w_req_instr, w_req_data;
  logic [STREAK_W-1:0] r_streak, w_streak_nxt;
  logic [WDOG_W-1:0]   r_wdog, w_wdog_nxt;
  logic                w_grant_i, w_grant_d;
  logic                w_fetch_pending;
  logic                w_wdog_hit;
  logic                w_busy;
  logic                w_abort;

  // Request payloads; a fetch is always a full-word read.
  always_comb begin
    w_req_instr.addr  = addr_instr_i;
    w_req_instr.wdata = '0;
    w_req_instr.rw    = 1'b0;
    w_req_instr.mask  = MEM_MASK_WORD;
    w_req_data.addr   = addr_data_i;
    w_req_data.wdata  = write_data_i;
    w_req_data.rw     = read_write_i;
    w_req_data.mask   = mask_data_i;
  end

  assign w_busy     = (r_state != IDLE);
  assign w_wdog_hit = (TIMEOUT_CYCLES != 0) && (r_wdog == WDOG_LAST);
  assign w_abort    = w_busy && !ready_i && w_wdog_hit;
  // A fetch just completing has its valid ignored for streak accounting.
  assign w_fetch_pending = valid_instr_i && (r_state != GNT_I);

  // State, latches and counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_req    <= '0;
      r_streak <= '0;
      r_wdog   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_req    <= w_req_nxt;
      r_streak <= w_streak_nxt;
      r_wdog   <= w_wdog_nxt;
    end
  end

  // Arbitration, completion hand-off and watchdog abort.
  always_comb begin
    w_state_nxt  = r_state;
    w_req_nxt    = r_req;
    w_streak_nxt = r_streak;
    w_wdog_nxt   = r_wdog;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;

    case (r_state)
      IDLE: begin
        if (valid_data_i && !(valid_instr_i && (r_streak == STREAK_LIMIT))) begin
          w_grant_d = 1'b1;
        end else if (valid_instr_i) begin
          w_grant_i = 1'b1;
        end
      end
      GNT_I: begin
        if (ready_i) begin
          if (valid_data_i) w_grant_d = 1'b1;
          else              w_state_nxt = IDLE;
        end else if (w_wdog_hit) begin
          w_state_nxt = IDLE;
        end
      end
      GNT_D: begin
        if (ready_i) begin
          if (valid_instr_i) w_grant_i = 1'b1;
          else               w_state_nxt = IDLE;
        end else if (w_wdog_hit) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_grant_d) begin
      w_state_nxt  = GNT_D;
      w_req_nxt    = w_req_data;
      w_wdog_nxt   = '0;
      w_streak_nxt = !w_fetch_pending ? '0 :
                     (r_streak == STREAK_MAX) ? r_streak : r_streak + STREAK_W'(1);
    end else if (w_grant_i) begin
      w_state_nxt  = GNT_I;
      w_req_nxt    = w_req_instr;
      w_wdog_nxt   = '0;
      w_streak_nxt = '0;
    end else if (!w_busy) begin
      w_wdog_nxt   = '0;
    end else if (r_wdog != WDOG_MAX) begin
      w_wdog_nxt   = r_wdog + WDOG_W'(1);
    end
  end

  // Requester-side responses; suppressed while reset is asserted.
  assign ready_instr_o = reset_n && (r_state == GNT_I) && (ready_i || w_abort);
  assign ready_data_o  = reset_n && (r_state == GNT_D) && (ready_i || w_abort);
  assign data_instr_o  = (ready_instr_o && ready_i) ? read_data_i : '0;
  assign read_data_o   = (ready_data_o && ready_i) ? read_data_i : '0;
  assign err_o         = reset_n && w_abort;

  // Memory-side request straight from the latches.
  assign valid_o      = w_busy;
  assign addr_o       = r_req.addr;
  assign write_data_o = r_req.wdata;
  assign read_write_o = r_req.rw;
  assign mask_o       = r_req.mask;

endmodule
